ps2_rx_fifo: RTL and testbench

- PS/2 keyboard receiver that sits directly upstream of the CPU bus peripheral decode in top_core.
- Samples the raw ps2_clk/ps2_data pins, deframes 11-bit PS/2 frames and checks odd parity and the stop bit.
- Buffers valid scan codes in a small FIFO. The CPU pops codes through a read-strobe interface and polls status bits.

---
 rtl/ps2_rx_fifo_if.sv | 33 +++
 rtl/ps2_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// CPU-side bus of the PS/2 receiver: pop strobe, head-of-FIFO data and sticky status flags.
interface ps2_rx_fifo_if;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_full;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output rd_en,
        output err_clr,
        input  rd_data,
        input  rd_valid,
        input  fifo_full,
        input  overflow,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rd_en,
        input  err_clr,
        output rd_data,
        output rd_valid,
        output fifo_full,
        output overflow,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames with parity/stop checks
// and queues good scan codes in a FIFO popped by the CPU.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input logic           clk,
    input logic           rst,
    input logic           ps2_clk,
    input logic           ps2_data,
    ps2_rx_fifo_if.slave  bus
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Input conditioning
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;
    logic       fall;
    logic       sdata;

    // Deframer
    state_e         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           push;
    logic           set_frame;
    logic           set_parity;

    // FIFO and flags
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           empty;
    logic           full;
    logic           pop;
    logic           wr_ok;
    logic           drop;
    logic           ovf_q, ovf_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;

    // clk_sync_q[1] is the synchronized level, clk_sync_q[2] its previous value.
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        fall       = clk_sync_q[2] & ~clk_sync_q[1];
        sdata      = dat_sync_q[1];
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        push       = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;

        if (state_q != StIdle) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!sdata) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end else begin
                        set_frame = 1'b1;
                    end
                end
                StData: begin
                    shreg_d = {sdata, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                StParity: begin
                    par_d   = sdata;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!sdata) begin
                        set_frame = 1'b1;
                    end else if (!(^{shreg_q, par_q})) begin
                        set_parity = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if ((state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
            // A stalled partial frame is abandoned; the next falling edge must be a start bit.
            state_d   = StIdle;
            tmo_d     = '0;
            set_frame = 1'b1;
        end
    end

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = bus.rd_en & ~empty;
        // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
        wr_ok = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_ptr_q + PW'(wr_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
        end

        // Set has priority over a coincident clear.
        ovf_d  = (ovf_q  & ~bus.err_clr) | drop;
        perr_d = (perr_q & ~bus.err_clr) | set_parity;
        ferr_d = (ferr_q & ~bus.err_clr) | set_frame;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            state_q    <= StIdle;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.rd_valid   = ~empty;
    assign bus.fifo_full  = full;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized bench for ps2_rx_fifo: a queue-based model of the PS/2 link feeds a scoreboard
// that a separate monitor drains whenever the CPU side pops a code.
module tb_ps2_rx_fifo;

    localparam int unsigned Depth = 8;
    localparam int unsigned Tmo   = 2000;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .FIFO_DEPTH    (Depth),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: accepted codes in order, plus the three sticky flags.
    logic [7:0] exp_q[$];
    bit exp_ovf = 1'b0;
    bit exp_par = 1'b0;
    bit exp_frm = 1'b0;
    logic [7:0] mon_exp;

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted pop must return the model's oldest code.
    always @(negedge clk) begin
        if (!rst && bus.rd_en) begin
            checks++;
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop: got data %02h expected empty FIFO", bus.rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.rd_data !== mon_exp) begin
                        errors++;
                        $display("FAIL pop_data: got %02h expected %02h", bus.rd_data, mon_exp);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pop_valid: got rd_valid 0 expected 1 (%0d queued)", exp_q.size());
            end
        end
    end

    task automatic clear_err();
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        exp_ovf = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
    endtask

    // strobe: 0 none, 1 rd_en, 2 err_clr -- asserted in the cycle the DUT acts on this falling edge.
    task automatic ps2_bit(input bit b, input int half, input int strobe);
        ps2_data = b;
        tick(half);
        ps2_clk = 1'b0;
        if (strobe != 0) begin
            tick(2);
            if (strobe == 1) bus.rd_en = 1'b1;
            else bus.err_clr = 1'b1;
            tick(1);
            bus.rd_en   = 1'b0;
            bus.err_clr = 1'b0;
            if (strobe == 2) begin
                exp_ovf = 1'b0;
                exp_par = 1'b0;
                exp_frm = 1'b0;
            end
            tick((half > 3) ? half - 3 : 0);
        end else begin
            tick(half);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int half, input int strobe);
        bit par;
        par = ~(^d) ^ bad_par;
        ps2_bit(1'b0, half, 0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], half, 0);
        ps2_bit(par, half, 0);
        ps2_bit(~bad_stop, half, strobe);
        ps2_data = 1'b1;
        tick(6);
        if (bad_stop) exp_frm = 1'b1;
        else if (bad_par) exp_par = 1'b1;
        else if (exp_q.size() >= Depth) exp_ovf = 1'b1;
        else exp_q.push_back(d);
    endtask

    task automatic rd_one();
        int n;
        n = 0;
        if (exp_q.size() != 0) begin
            while (!bus.rd_valid && n < 50) begin
                tick(1);
                n++;
            end
            chk("rd_wait", bus.rd_valid, 1);
        end
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        tick(1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".rd_valid"}, bus.rd_valid, (exp_q.size() != 0));
        chk({tag, ".fifo_full"}, bus.fifo_full, (exp_q.size() == Depth));
        chk({tag, ".overflow"}, bus.overflow, exp_ovf);
        chk({tag, ".parity_err"}, bus.parity_err, exp_par);
        chk({tag, ".frame_err"}, bus.frame_err, exp_frm);
        chk({tag, ".rd_data"}, bus.rd_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".outputs"},
            {24'h0, bus.rd_data} | {bus.rd_valid, bus.fifo_full, bus.overflow, bus.parity_err,
                                    bus.frame_err, 3'b000, 8'h00},
            32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        tick(3);
        rst = 1'b0;
        tick(2);
        check_status("after_reset");

        // Single frame with a one-clk low phase
        send_frame(8'h16, 1'b0, 1'b0, 1, 0);
        check_status("single");
        rd_one();
        check_status("single_drained");

        // Break sequence back-to-back
        send_frame(8'h16, 1'b0, 1'b0, 2, 0);
        send_frame(8'hF0, 1'b0, 1'b0, 2, 0);
        send_frame(8'h16, 1'b0, 1'b0, 2, 0);
        chk("break_count_valid", bus.rd_valid, 1);
        for (int i = 0; i < 3; i++) rd_one();
        check_status("break_drained");
        rd_one();  // pop while empty is ignored
        check_status("empty_pop");

        // Parity error, stop error, bad start bit
        send_frame(8'h16, 1'b1, 1'b0, 2, 0);
        check_status("parity");
        clear_err();
        check_status("parity_clr");
        send_frame(8'h55, 1'b0, 1'b1, 3, 0);
        check_status("stop_err");
        clear_err();
        ps2_bit(1'b1, 2, 0);
        tick(6);
        exp_frm = 1'b1;
        check_status("bad_start");
        clear_err();

        // err_clr coincident with a new parity error: the set wins
        send_frame(8'h3C, 1'b1, 1'b0, 2, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 3, 2);
        check_status("clr_vs_set");
        clear_err();

        // Overflow
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1, 0);
            if (i == 8) check_status("fill8");
        end
        check_status("overflow");
        for (int i = 0; i < 8; i++) rd_one();
        check_status("ovf_drained");
        clear_err();

        // Push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1, 0);
        send_frame(8'hA7, 1'b0, 1'b0, 3, 1);
        check_status("full_push_pop");
        for (int i = 0; i < 8; i++) rd_one();
        check_status("full_push_pop_drained");

        // Timeout after 4 data bits, then a clean frame
        ps2_bit(1'b0, 2, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i), 2, 0);
        tick(Tmo - 100);
        chk("timeout_early", bus.frame_err, 0);
        tick(200);
        exp_frm = 1'b1;
        check_status("timeout");
        clear_err();
        send_frame(8'h1C, 1'b0, 1'b0, 2, 0);
        check_status("after_timeout");
        rd_one();

        // Reset during bit 3 with a code already queued
        send_frame(8'h33, 1'b0, 1'b0, 2, 0);
        ps2_bit(1'b0, 2, 0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 2, 0);
        ps2_data = 1'b0;
        tick(2);
        ps2_clk = 1'b0;
        tick(1);
        rst = 1'b1;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check_status("post_reset");
        send_frame(8'h2A, 1'b0, 1'b0, 2, 0);
        check_status("post_reset_frame");
        rd_one();

        // Randomized frames, errors and reads
        for (int n = 0; n < 40; n++) begin
            int kind;
            int nrd;
            kind = $urandom_range(0, 9);
            send_frame(8'($urandom), (kind == 0), (kind == 1), $urandom_range(1, 4), 0);
            check_status("rand");
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) rd_one();
            if ($urandom_range(0, 7) == 0) clear_err();
        end
        while (exp_q.size() != 0) rd_one();
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
